// File: rtl/fifo_wptr_full_if.sv
// Write-side bus of the async FIFO pointer block: producer controls in, pointers and flags out.
interface fifo_wptr_full_if #(
  parameter int unsigned PTR_WIDTH = 4
);
  logic                 w_en;
  logic [PTR_WIDTH:0]   g_read_ptr;
  logic                 ovf_clr;
  logic [PTR_WIDTH:0]   b_write_ptr;
  logic [PTR_WIDTH:0]   g_write_ptr;
  logic                 full;
  logic                 almost_full;
  logic [PTR_WIDTH:0]   wr_count;
  logic                 overflow;

  modport master (
    output w_en, g_read_ptr, ovf_clr,
    input  b_write_ptr, g_write_ptr, full, almost_full, wr_count, overflow
  );

  modport slave (
    input  w_en, g_read_ptr, ovf_clr,
    output b_write_ptr, g_write_ptr, full, almost_full, wr_count, overflow
  );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer/flag generator: binary+Gray write pointer, read-pointer
// synchronizer, full/almost_full, fill count and sticky overflow.
module fifo_wptr_full #(
  parameter int unsigned PTR_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_LEVEL    = 12
) (
  input logic              w_clk,
  input logic              w_rst,
  fifo_wptr_full_if.slave  bus
);
  localparam int unsigned PW = PTR_WIDTH + 1;

  logic [PW-1:0] b_ptr_q;
  logic [PW-1:0] g_ptr_q;
  logic [PW-1:0] cnt_q;
  logic          full_q;
  logic          af_q;
  logic          ovf_q;
  logic [PW-1:0] sync_q [SYNC_STAGES];

  logic          w_inc_c;
  logic [PW-1:0] b_next_c;
  logic [PW-1:0] g_next_c;
  logic [PW-1:0] rq_c;
  logic [PW-1:0] rbin_c;
  logic [PW-1:0] count_c;
  logic          full_next_c;
  logic          ovf_next_c;

  // Next pointer, synchronized read pointer decode and flag evaluation
  always_comb begin
    w_inc_c  = bus.w_en & ~full_q;
    b_next_c = b_ptr_q + PW'(w_inc_c);
    g_next_c = b_next_c ^ (b_next_c >> 1);
    rq_c     = sync_q[SYNC_STAGES-1];
    rbin_c   = '0;
    for (int i = 0; i < int'(PW); i++) begin
      rbin_c[i] = ^(rq_c >> i);
    end
    count_c     = b_next_c - rbin_c;
    // Full when write pointer is exactly one lap ahead of the read pointer
    full_next_c = (g_next_c == {~rq_c[PTR_WIDTH:PTR_WIDTH-1], rq_c[PTR_WIDTH-2:0]});
    // A write attempt while full wins over a same-cycle clear
    ovf_next_c  = ovf_q;
    if (bus.w_en && full_q) begin
      ovf_next_c = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_next_c = 1'b0;
    end
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      b_ptr_q <= '0;
      g_ptr_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      b_ptr_q <= b_next_c;
      g_ptr_q <= g_next_c;
      cnt_q   <= count_c;
      full_q  <= full_next_c;
      af_q    <= (count_c >= PW'(AF_LEVEL));
      ovf_q   <= ovf_next_c;
      sync_q[0] <= bus.g_read_ptr;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bus.b_write_ptr = b_ptr_q;
  assign bus.g_write_ptr = g_ptr_q;
  assign bus.wr_count    = cnt_q;
  assign bus.full        = full_q;
  assign bus.almost_full = af_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: directed vector table, wraparound sequence and
// randomized traffic against an occupancy-based reference model.
module tb_fifo_wptr_full;
  localparam int unsigned PTR_WIDTH   = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned AF_LEVEL    = 12;
  localparam int          DEPTH       = 16;
  localparam int          MODV        = 32;

  logic       w_clk = 1'b0;
  logic       rst   = 1'b1;
  logic       wen   = 1'b0;
  logic       clr   = 1'b0;
  logic [4:0] rp_bin = '0;

  int total = 0;
  int bad   = 0;

  fifo_wptr_full_if #(.PTR_WIDTH(PTR_WIDTH)) bus ();

  assign bus.w_en       = wen;
  assign bus.ovf_clr    = clr;
  assign bus.g_read_ptr = rp_bin ^ (rp_bin >> 1);

  fifo_wptr_full #(
    .PTR_WIDTH  (PTR_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .AF_LEVEL   (AF_LEVEL)
  ) dut (
    .w_clk(w_clk),
    .w_rst(rst),
    .bus  (bus)
  );

  always #5 w_clk = ~w_clk;

  // Reference model: written-entry counter, delayed view of the read pointer
  int m_wp   = 0;
  bit m_full = 0;
  bit m_af   = 0;
  int m_cnt  = 0;
  bit m_ovf  = 0;
  int m_q[$];

  typedef struct {
    logic       rst, wen, clr;
    logic [4:0] rp;
    logic [4:0] eb;
    logic       ef, eaf;
    logic [4:0] ecnt;
    logic       eovf;
  } vec_t;
  vec_t tbl[$];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void add(logic r, logic w, logic c, logic [4:0] rp, logic [4:0] eb,
                              logic ef, logic eaf, logic [4:0] ecnt, logic eovf);
    vec_t v;
    v.rst = r; v.wen = w; v.clr = c; v.rp = rp; v.eb = eb;
    v.ef = ef; v.eaf = eaf; v.ecnt = ecnt; v.eovf = eovf;
    tbl.push_back(v);
  endfunction

  function automatic logic [4:0] gray(logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  // One clock edge: advance the model, then compare the DUT against it
  task automatic step();
    int  rv, occ;
    bit  set;
    logic [4:0] wp5;
    @(posedge w_clk);
    if (rst) begin
      m_wp = 0; m_full = 0; m_af = 0; m_cnt = 0; m_ovf = 0;
      m_q.delete();
      repeat (SYNC_STAGES) m_q.push_back(0);
    end else begin
      rv = m_q.pop_front();
      m_q.push_back(int'(rp_bin));
      set = wen && m_full;
      if (wen && !m_full) m_wp = (m_wp + 1) % MODV;
      occ    = (m_wp + MODV - rv) % MODV;
      m_full = (occ == DEPTH);
      m_af   = (occ >= int'(AF_LEVEL));
      m_cnt  = occ;
      if (set) m_ovf = 1;
      else if (clr) m_ovf = 0;
    end
    #1;
    wp5 = 5'(m_wp);
    check("model_bptr", 32'(bus.b_write_ptr), 32'(wp5));
    check("model_gptr", 32'(bus.g_write_ptr), 32'(gray(wp5)));
    check("model_full", 32'(bus.full), 32'(m_full));
    check("model_af",   32'(bus.almost_full), 32'(m_af));
    check("model_cnt",  32'(bus.wr_count), 32'(m_cnt));
    check("model_ovf",  32'(bus.overflow), 32'(m_ovf));
  endtask

  initial begin
    logic [4:0] prev_g;
    int rt;
    bit saw_wrap;

    repeat (SYNC_STAGES) m_q.push_back(0);

    // Reset held with write request and a nonzero read pointer
    add(1, 1, 0, 5'd4, 0, 0, 0, 0, 0);
    add(1, 1, 0, 5'd4, 0, 0, 0, 0, 0);
    // Fill from empty
    for (int i = 1; i <= DEPTH; i++)
      add(0, 1, 0, 0, 5'(i), i == DEPTH, i >= int'(AF_LEVEL), 5'(i), 0);
    // Writes while full
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 5'd16, 1, 1, 5'd16, 1);
    add(0, 0, 1, 0, 5'd16, 1, 1, 5'd16, 0);
    add(0, 0, 0, 0, 5'd16, 1, 1, 5'd16, 0);
    add(0, 1, 1, 0, 5'd16, 1, 1, 5'd16, 1);
    add(0, 0, 0, 0, 5'd16, 1, 1, 5'd16, 1);
    // Drain visibility: read pointer to 4, then 5
    add(0, 0, 0, 5'd4, 5'd16, 1, 1, 5'd16, 1);
    add(0, 0, 0, 5'd4, 5'd16, 1, 1, 5'd16, 1);
    add(0, 0, 0, 5'd4, 5'd16, 0, 1, 5'd12, 1);
    add(0, 0, 0, 5'd5, 5'd16, 0, 1, 5'd12, 1);
    add(0, 0, 0, 5'd5, 5'd16, 0, 1, 5'd12, 1);
    add(0, 0, 0, 5'd5, 5'd16, 0, 0, 5'd11, 1);
    // Reset mid-burst after 7 writes
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) add(0, 1, 0, 0, 5'(i), 0, 0, 5'(i), 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 5'd1, 0, 0, 5'd1, 0);
    add(0, 0, 0, 0, 5'd1, 0, 0, 5'd1, 0);

    foreach (tbl[k]) begin
      rst = tbl[k].rst; wen = tbl[k].wen; clr = tbl[k].clr; rp_bin = tbl[k].rp;
      step();
      check($sformatf("vec%0d_bptr", k), 32'(bus.b_write_ptr), 32'(tbl[k].eb));
      check($sformatf("vec%0d_gptr", k), 32'(bus.g_write_ptr), 32'(gray(tbl[k].eb)));
      check($sformatf("vec%0d_full", k), 32'(bus.full), 32'(tbl[k].ef));
      check($sformatf("vec%0d_af",   k), 32'(bus.almost_full), 32'(tbl[k].eaf));
      check($sformatf("vec%0d_cnt",  k), 32'(bus.wr_count), 32'(tbl[k].ecnt));
      check($sformatf("vec%0d_ovf",  k), 32'(bus.overflow), 32'(tbl[k].eovf));
    end

    // Wraparound with the read pointer trailing four entries behind
    rst = 1; wen = 0; clr = 0; rp_bin = 0;
    step();
    rst = 0;
    prev_g = bus.g_write_ptr;
    saw_wrap = 0;
    for (int n = 1; n <= 40; n++) begin
      wen = 1;
      rp_bin = (n > 5) ? 5'(n - 5) : 5'd0;
      step();
      check($sformatf("wrap%0d_gray1bit", n), 32'($countones(bus.g_write_ptr ^ prev_g)), 32'd1);
      check($sformatf("wrap%0d_nofull", n), 32'(bus.full), 32'd0);
      check($sformatf("wrap%0d_cnt_hi", n), 32'(bus.wr_count <= 5'd7), 32'd1);
      if (n >= 4) check($sformatf("wrap%0d_cnt_lo", n), 32'(bus.wr_count >= 5'd4), 32'd1);
      if (n == 32) begin
        check("wrap_to_zero", 32'(bus.b_write_ptr), 32'd0);
        saw_wrap = 1;
      end
      prev_g = bus.g_write_ptr;
    end
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    // Randomized traffic with a legal, trailing read pointer
    wen = 0;
    rst = 1; rp_bin = 0; step();
    rst = 0; rt = 0;
    for (int i = 0; i < 3000; i++) begin
      int rd_pct;
      rd_pct = ((i / 300) % 2 == 0) ? 20 : 70;
      rst = ($urandom_range(0, 399) == 0);
      wen = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 7) == 0);
      if (rst) rt = 0;
      else if (rt != m_wp && $urandom_range(0, 99) < rd_pct) rt = (rt + 1) % MODV;
      rp_bin = 5'(rt);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_wptr_full.md
Name: fifo_wptr_full

Overview:
- Write-side pointer and flag generator for the asynchronous FIFO. Runs entirely in the write clock domain.
- Produces the binary write pointer that addresses the FIFO storage array and the Gray write pointer exported to the read domain.
- Synchronizes the incoming Gray read pointer and derives full, almost_full, fill count and a sticky overflow flag.
- Sits directly upstream of the FIFO memory. It drives that block's b_write_ptr and full inputs.

Parameters:
- PTR_WIDTH, 4: address bits. FIFO depth is 2**PTR_WIDTH. Pointers are PTR_WIDTH+1 bits wide. Minimum legal value is 2.
- SYNC_STAGES, 2: number of flops in the read-pointer synchronizer chain. Minimum legal value is 2.
- AF_LEVEL, 12: almost_full asserts when fill count >= AF_LEVEL. Legal range is 1..2**PTR_WIDTH.

Ports:
- w_clk  input  1  write-domain clock. Every flop in the block is clocked on its rising edge.
- w_rst  input  1  synchronous, active-high reset.
- w_en  input  1  write request from the producer.
- g_read_ptr  input  PTR_WIDTH+1  Gray read pointer from the read domain. Treated as asynchronous.
- ovf_clr  input  1  clears the sticky overflow flag.
- b_write_ptr  output  PTR_WIDTH+1  binary write pointer. Its low PTR_WIDTH bits address the memory.
- g_write_ptr  output  PTR_WIDTH+1  Gray write pointer, registered, sent to the read-domain synchronizer.
- full  output  1  FIFO full, registered.
- almost_full  output  1  fill count >= AF_LEVEL, registered.
- wr_count  output  PTR_WIDTH+1  write-side fill count, 0..2**PTR_WIDTH, registered.
- overflow  output  1  sticky flag: a write was attempted while full.

Behaviour:

Reset (w_rst=1 at a rising edge):
- All outputs go to 0.
- All synchronizer flops go to 0.
- w_en is ignored in the reset cycle.
- Reset asserted mid-burst discards pointer state. Normal operation resumes on the first edge with w_rst=0.

Write acceptance:
- w_inc = w_en & ~full.
- b_next = b_write_ptr + w_inc, modulo 2**(PTR_WIDTH+1). The pointer wraps from all-ones to 0.
- g_next = b_next ^ (b_next >> 1).
- Every edge: b_write_ptr <= b_next and g_write_ptr <= g_next.
- Successive values of g_write_ptr differ in exactly one bit, including across the wrap.

Synchronizer:
- sync[0] <= g_read_ptr, and sync[i] <= sync[i-1] for each later stage.
- rq = sync[SYNC_STAGES-1].
- Combinational gray-to-binary conversion: rbin[MSB] = rq[MSB]; rbin[i] = rbin[i+1] ^ rq[i].

Full:
- full <= (g_next == {~rq[P:P-1], rq[P-2:0]}), where P = PTR_WIDTH.
- full rises on the same edge that accepts the 2**PTR_WIDTH-th outstanding write. There is no extra cycle of latency.

Count and almost_full:
- wr_count <= b_next - rbin, modulo 2**(PTR_WIDTH+1).
- almost_full <= (b_next - rbin) >= AF_LEVEL.

Read-pointer latency:
- A change on g_read_ptr reaches full, wr_count and almost_full after SYNC_STAGES+1 rising edges.
- Flags are pessimistic. full and almost_full may stay high longer than the true state, but never deassert early.

Writes while full:
- The pointers hold.
- overflow <= 1 on that edge.

Overflow clearing:
- ovf_clr=1 clears overflow on the next edge.
- If a set condition and ovf_clr occur in the same cycle, set wins and overflow = 1.

Simultaneous write and read advance:
- Both take effect.
- wr_count reflects the new write immediately and the read advance after the synchronizer latency.

Test Plan:
1. Reset check: hold w_rst=1 for 2 edges with w_en=1 and g_read_ptr=5'b00110 -> all outputs 0, and b_write_ptr stays 0.
2. Fill from empty: g_read_ptr=0, then 16 consecutive writes.
   - almost_full rises on the edge of the 12th write (wr_count=12).
   - full rises on the edge of the 16th write, with b_write_ptr=5'b10000, g_write_ptr=5'b11000 and wr_count=16.
3. Overflow while full:
   - 3 further writes -> b_write_ptr holds at 16 and overflow=1 stays high.
   - Pulse ovf_clr with w_en=0 -> overflow=0 next edge.
   - Repeat with ovf_clr=1 and w_en=1 together -> overflow remains 1.
4. Drain visibility: while full, set g_read_ptr=5'b00110 (binary 4).
   - full stays 1 for 2 edges, then clears on the 3rd edge.
   - On that edge wr_count=12 and almost_full=1.
   - Then set g_read_ptr=gray(5)=5'b00111 -> almost_full=0 after 3 edges.
5. Wraparound: 40 writes with g_read_ptr tracking the write pointer 4 entries behind.
   - b_write_ptr wraps 31->0 with no full assertion.
   - Every g_write_ptr transition changes exactly 1 bit.
   - wr_count stays in 4..7.
6. Reset mid-burst: assert w_rst after 7 writes -> next edge all outputs 0. After release, the first write gives b_write_ptr=1 and g_write_ptr=1.
